// File: rtl/stdp_update_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// stdp_sched_pkg : state encoding, width defaults and arithmetic helpers
// Rev 1.0
// ============================================================================
package stdp_sched_pkg;

   localparam int unsigned DEF_N_PRE      = 8;
   localparam int unsigned DEF_FIFO_DEPTH = 4;
   localparam int unsigned IDX_BITS       = $clog2(DEF_N_PRE);
   localparam int unsigned PTR_BITS       = $clog2(DEF_FIFO_DEPTH);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_FETCH   = 3'd1;
   localparam logic [2:0] S_CAPTURE = 3'd2;
   localparam logic [2:0] S_ENGINE  = 3'd3;
   localparam logic [2:0] S_WRITE   = 3'd4;
   localparam logic [2:0] S_NEXT    = 3'd5;
   localparam logic [2:0] S_DONE    = 3'd6;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Unsigned weight plus signed delta, evaluated in 10 bits and clamped to [0, wmax].
   function automatic logic [7:0] clamp_weight(input logic [7:0] w,
                                               input logic [7:0] d,
                                               input logic [7:0] wmax);
      logic signed [9:0] s;
      s = $signed({2'b00, w}) + $signed({{2{d[7]}}, d});
      if (s[9])
         return 8'd0;
      else if (s > $signed({2'b00, wmax}))
         return wmax;
      else
         return s[7:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/stdp_update_scheduler_event_fifo.sv
`default_nettype none
// ============================================================================
// stdp_event_fifo : synchronous FIFO for post-spike {neuron, time} events
// Rev 1.0
// ============================================================================
module stdp_event_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 11
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned c_PTR_BITS = $clog2(DEPTH);

   logic [WIDTH-1:0]      r_mem [DEPTH];
   logic [c_PTR_BITS-1:0] r_wr_ptr;
   logic [c_PTR_BITS-1:0] r_rd_ptr;
   logic [c_PTR_BITS:0]   r_count;
   logic                  w_do_push;
   logic                  w_do_pop;

   // A push while full is refused even if a pop happens in the same cycle.
   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;

   assign full  = (r_count == (c_PTR_BITS+1)'(DEPTH));
   assign empty = (r_count == '0);
   assign count = r_count;
   assign head  = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_do_push && !w_do_pop)
            r_count <= r_count + 1'b1;
         else if (w_do_pop && !w_do_push)
            r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push)
         r_mem[r_wr_ptr] <= push_data;
   end

endmodule
`default_nettype wire

// File: rtl/stdp_update_scheduler.sv
`default_nettype none
// ============================================================================
// stdp_update_scheduler : walks every pre-synaptic input of each queued
// post-spike event through the shared STDP engine and writes back weights.
// Rev 1.0
// ============================================================================
module stdp_update_scheduler
   import stdp_sched_pkg::*;
#(
   parameter int unsigned N_PRE       = DEF_N_PRE,
   parameter int unsigned NEURON_BITS = 3,
   parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
   parameter int unsigned W_MAX       = 255,
   parameter int unsigned ENG_TIMEOUT = 15
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  enable,
   input  logic                                  post_valid,
   input  logic [NEURON_BITS-1:0]                post_neuron,
   input  logic [7:0]                            post_time,
   output logic                                  post_ready,
   output logic [$clog2(N_PRE)-1:0]              pre_rd_addr,
   input  logic [7:0]                            pre_rd_data,
   input  logic                                  pre_rd_seen,
   output logic [NEURON_BITS+$clog2(N_PRE)-1:0]  syn_addr,
   output logic                                  syn_rd_en,
   input  logic [7:0]                            syn_rd_data,
   output logic                                  syn_wr_en,
   output logic [7:0]                            syn_wr_data,
   output logic                                  eng_req,
   output logic [7:0]                            eng_pre_time,
   output logic [7:0]                            eng_post_time,
   input  logic                                  eng_ack,
   input  logic [7:0]                            eng_delta,
   input  logic                                  eng_update,
   output logic                                  busy,
   output logic                                  event_done,
   output logic [15:0]                           events_processed,
   output logic [15:0]                           updates_written,
   output logic [15:0]                           drops,
   output logic [15:0]                           timeouts
);

   localparam int unsigned c_IDX_BITS = $clog2(N_PRE);
   localparam int unsigned c_CNT_BITS = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned c_TO_BITS  = $clog2(ENG_TIMEOUT + 1);
   localparam int unsigned c_EV_BITS  = NEURON_BITS + 8;

   logic [2:0]             r_state;
   logic [2:0]             w_next;

   logic [NEURON_BITS-1:0] r_neuron;
   logic [7:0]             r_post_time;
   logic [c_IDX_BITS-1:0]  r_idx;
   logic [7:0]             r_pre_time;
   logic [7:0]             r_weight;
   logic [7:0]             r_delta;
   logic [c_TO_BITS-1:0]   r_tcnt;

   logic [c_EV_BITS-1:0]   w_head;
   logic                   w_full;
   logic                   w_empty;
   logic [c_CNT_BITS-1:0]  w_count;
   logic                   w_start;
   logic                   w_last_idx;
   logic                   w_timeout;
   logic                   w_drop;

   stdp_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (c_EV_BITS)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (post_valid),
      .push_data ({post_neuron, post_time}),
      .pop       (r_state == S_DONE),
      .head      (w_head),
      .full      (w_full),
      .empty     (w_empty),
      .count     (w_count)
   );

   assign post_ready = !w_full;
   assign w_drop     = post_valid && (w_count == c_CNT_BITS'(FIFO_DEPTH));
   assign w_start    = (r_state == S_IDLE) && enable && !w_empty;
   assign w_last_idx = (r_idx == c_IDX_BITS'(N_PRE - 1));
   assign w_timeout  = (r_state == S_ENGINE) && !eng_ack &&
                       (r_tcnt == c_TO_BITS'(ENG_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (w_start) w_next = S_FETCH;
         S_FETCH:   w_next = S_CAPTURE;
         S_CAPTURE: w_next = pre_rd_seen ? S_ENGINE : S_NEXT;
         S_ENGINE: begin
            if (eng_ack)
               w_next = eng_update ? S_WRITE : S_NEXT;
            else if (w_timeout)
               w_next = S_NEXT;
         end
         S_WRITE:   w_next = S_NEXT;
         S_NEXT:    w_next = w_last_idx ? S_DONE : S_FETCH;
         S_DONE:    w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_comb begin
      pre_rd_addr   = r_idx;
      syn_addr      = {r_neuron, r_idx};
      syn_rd_en     = (r_state == S_FETCH);
      syn_wr_en     = (r_state == S_WRITE);
      syn_wr_data   = 8'd0;
      eng_req       = (r_state == S_ENGINE);
      eng_pre_time  = r_pre_time;
      eng_post_time = r_post_time;
      busy          = (r_state != S_IDLE);
      event_done    = (r_state == S_DONE);
      if (r_state == S_WRITE)
         syn_wr_data = clamp_weight(r_weight, r_delta, 8'(W_MAX));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_neuron    <= '0;
         r_post_time <= '0;
         r_idx       <= '0;
         r_pre_time  <= '0;
         r_weight    <= '0;
         r_delta     <= '0;
         r_tcnt      <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_neuron    <= w_head[c_EV_BITS-1:8];
                  r_post_time <= w_head[7:0];
                  r_idx       <= '0;
               end
            end
            S_CAPTURE: begin
               r_pre_time <= pre_rd_data;
               r_weight   <= syn_rd_data;
               r_tcnt     <= '0;
            end
            S_ENGINE: begin
               r_tcnt <= r_tcnt + 1'b1;
               if (eng_ack && eng_update)
                  r_delta <= eng_delta;
            end
            S_NEXT: begin
               if (!w_last_idx)
                  r_idx <= r_idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         events_processed <= '0;
         updates_written  <= '0;
         drops            <= '0;
         timeouts         <= '0;
      end else begin
         if (r_state == S_DONE)
            events_processed <= sat_inc16(events_processed);
         if (r_state == S_WRITE)
            updates_written <= sat_inc16(updates_written);
         if (w_drop)
            drops <= sat_inc16(drops);
         if (w_timeout)
            timeouts <= sat_inc16(timeouts);
      end
   end

endmodule
`default_nettype wire
